// File: rtl/dt_res_packer.sv
// dt_res_packer
//   Streams the 128x128 8-bit distance-transform result RAM back out after the
//   transform has finished. Each pixel is thresholded to one bit and 16 pixels
//   are packed MSB-first into one 16-bit word, which is written to the packed
//   output memory. The block also reports the largest distance seen and the
//   number of object pixels for the frame.
//
//   Ports
//     clk       in   1   rising-edge clock
//     reset     in   1   asynchronous, active-low reset
//     start     in   1   begin a frame (accepted only in IDLE or FIN)
//     res_rd    out  1   result-RAM read strobe
//     res_addr  out  14  result-RAM pixel address
//     res_di    in   8   result-RAM read data, one cycle after res_rd
//     out_wr    out  1   packed-word write strobe (1-cycle pulse)
//     out_addr  out  10  packed-word address
//     out_do    out  16  packed word, bit 15-k = pixel 16*out_addr+k
//     max_dist  out  8   running max of res_di, valid while done=1
//     obj_cnt   out  15  count of pixels above THRESH, valid while done=1
//     done      out  1   frame complete, held until the next start
//
//   State table
//     S_IDLE  | out of reset, waiting for start
//     S_RD    | 16 cycles, one pixel read per cycle
//     S_DRAIN | last read's data arrives; word is assembled and registered
//     S_WR    | out_wr pulse; advance to next word or finish
//     S_FIN   | frame complete, done held high, waiting for start
module dt_res_packer #(
  parameter logic [7:0] THRESH  = 8'd0,
  parameter int         N_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        out_wr,
  output logic [9:0]  out_addr,
  output logic [15:0] out_do,
  output logic [7:0]  max_dist,
  output logic [14:0] obj_cnt,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_DRAIN = 3'd2,
    S_WR    = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [9:0] LAST_WORD = 10'(N_WORDS - 1);

  state_t      r_state;
  logic        r_res_rd;
  logic [13:0] r_res_addr;
  logic [3:0]  r_k;
  logic [9:0]  r_word;
  logic        r_out_wr;
  logic [9:0]  r_out_addr;
  logic [15:0] r_out_do;
  logic        r_done;
  logic        r_cap_vld;
  logic [15:0] r_shift;
  logic [7:0]  r_max;
  logic [14:0] r_cnt;

  state_t      w_nxt_state;
  logic        w_nxt_rd;
  logic [13:0] w_nxt_addr;
  logic [3:0]  w_nxt_k;
  logic [9:0]  w_nxt_word;
  logic        w_nxt_wr;
  logic [9:0]  w_nxt_oaddr;
  logic [15:0] w_nxt_odo;
  logic        w_nxt_done;
  logic        w_clr;
  logic        w_bit;

  assign w_bit = (res_di > THRESH);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rd    = 1'b0;
    w_nxt_addr  = r_res_addr;
    w_nxt_k     = r_k;
    w_nxt_word  = r_word;
    w_nxt_wr    = 1'b0;
    w_nxt_oaddr = r_out_addr;
    w_nxt_odo   = r_out_do;
    w_nxt_done  = r_done;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          w_nxt_state = S_RD;
          w_nxt_rd    = 1'b1;
          w_nxt_addr  = 14'd0;
          w_nxt_k     = 4'd0;
          w_nxt_word  = 10'd0;
          w_nxt_done  = 1'b0;
          w_clr       = 1'b1;
        end
      end
      S_RD: begin
        if (r_k == 4'd15) begin
          w_nxt_state = S_DRAIN;
        end else begin
          w_nxt_rd   = 1'b1;
          w_nxt_addr = r_res_addr + 14'd1;
          w_nxt_k    = r_k + 4'd1;
        end
      end
      S_DRAIN: begin
        // The 16th pixel is arriving now; fold it in without waiting for the shift.
        w_nxt_state = S_WR;
        w_nxt_wr    = 1'b1;
        w_nxt_oaddr = r_word;
        w_nxt_odo   = {r_shift[14:0], w_bit};
      end
      S_WR: begin
        if (r_word == LAST_WORD) begin
          w_nxt_state = S_FIN;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_state = S_RD;
          w_nxt_rd    = 1'b1;
          w_nxt_addr  = r_res_addr + 14'd1;
          w_nxt_k     = 4'd0;
          w_nxt_word  = r_word + 10'd1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_res_rd   <= 1'b0;
      r_res_addr <= 14'd0;
      r_k        <= 4'd0;
      r_word     <= 10'd0;
      r_out_wr   <= 1'b0;
      r_out_addr <= 10'd0;
      r_out_do   <= 16'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_res_rd   <= w_nxt_rd;
      r_res_addr <= w_nxt_addr;
      r_k        <= w_nxt_k;
      r_word     <= w_nxt_word;
      r_out_wr   <= w_nxt_wr;
      r_out_addr <= w_nxt_oaddr;
      r_out_do   <= w_nxt_odo;
      r_done     <= w_nxt_done;
    end
  end

  // Capture only in the cycle after a real read; res_di is garbage otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_vld <= 1'b0;
      r_shift   <= 16'd0;
      r_max     <= 8'd0;
      r_cnt     <= 15'd0;
    end else begin
      r_cap_vld <= r_res_rd;
      if (w_clr) begin
        r_max <= 8'd0;
        r_cnt <= 15'd0;
      end else if (r_cap_vld) begin
        r_shift <= {r_shift[14:0], w_bit};
        if (res_di > r_max) r_max <= res_di;
        if (w_bit) r_cnt <= r_cnt + 15'd1;
      end
    end
  end

  assign res_rd   = r_res_rd;
  assign res_addr = r_res_addr;
  assign out_wr   = r_out_wr;
  assign out_addr = r_out_addr;
  assign out_do   = r_out_do;
  assign max_dist = r_max;
  assign obj_cnt  = r_cnt;
  assign done     = r_done;

endmodule

// File: tb/tb_dt_res_packer.sv
module tb_dt_res_packer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        out_wr;
  logic [9:0]  out_addr;
  logic [15:0] out_do;
  logic [7:0]  max_dist;
  logic [14:0] obj_cnt;
  logic        done;

  dt_res_packer #(.THRESH(8'd0), .N_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .out_wr(out_wr), .out_addr(out_addr), .out_do(out_do),
    .max_dist(max_dist), .obj_cnt(obj_cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
    int          c;
  } exp_t;

  logic [7:0]  mem [16384];
  logic [15:0] got [1024];
  exp_t        q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  int exp_addr = 0;
  int last_wr = 0;
  bit have_wr = 0;
  int wr_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result RAM: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
    else        res_di <= 8'($urandom);
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  // Scoreboard producer: expected packed words for the current mem contents.
  task automatic push_frame();
    exp_t e;
    for (int w = 0; w < 1024; w++) begin
      e.a = 10'(w);
      e.d = 16'd0;
      for (int k = 0; k < 16; k++) e.d[15-k] = (mem[16*w+k] > 8'd0);
      e.c = t_start + 18*(w+1);
      q.push_back(e);
    end
  endtask

  // Monitor / protocol checker
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (res_rd && out_wr) chk("rd_wr_overlap", 1, 0);
      if (res_rd) begin
        chk("res_addr_inc", int'(res_addr), exp_addr);
        exp_addr = int'(res_addr) + 1;
      end
      if (out_wr) begin
        if (have_wr) chk("wr_spacing", cyc - last_wr, 18);
        last_wr = cyc;
        have_wr = 1;
        got[out_addr] = out_do;
        wr_count++;
        if (q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_addr", int'(out_addr), int'(e.a));
          chk("out_do", int'(out_do), int'(e.d));
          chk("wr_cycle", cyc - t_start, e.c - t_start);
        end
      end
    end
  end

  task automatic do_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    t_start = cyc;
    exp_addr = 0;
    have_wr = 0;
    wr_count = 0;
    for (int i = 0; i < 1024; i++) got[i] = 16'hDEAD;
    push_frame();
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    exp_addr = 0;
    chk("done_seen", int'(seen), 1);
    chk("done_cycle", cyc - t_start, 18433);
    chk("write_count", wr_count, 1024);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_res_rd"}, int'(res_rd), 0);
    chk({tag, "_res_addr"}, int'(res_addr), 0);
    chk({tag, "_out_wr"}, int'(out_wr), 0);
    chk({tag, "_out_addr"}, int'(out_addr), 0);
    chk({tag, "_out_do"}, int'(out_do), 0);
    chk({tag, "_max_dist"}, int'(max_dist), 0);
    chk({tag, "_obj_cnt"}, int'(obj_cnt), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int p = 0; p < 16384; p++) mem[p] = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_rd", int'(res_rd), 0);
    chk("idle_done", int'(done), 0);

    // Frame A: ramp image, with a start pulse mid-frame that must be ignored.
    for (int p = 0; p < 16384; p++) mem[p] = 8'(p);
    do_start(0);
    while (cyc < t_start + 5000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ramp_max", int'(max_dist), 255);
    chk("ramp_cnt", int'(obj_cnt), 16320);
    chk("ramp_word0", int'(got[0]), 16'h7FFF);
    chk("ramp_word16", int'(got[16]), 16'h7FFF);
    chk("ramp_word1", int'(got[1]), 16'hFFFF);

    // Frame B: all-zero image, restarted from FIN.
    for (int p = 0; p < 16384; p++) mem[p] = 8'd0;
    repeat (4) @(negedge clk);
    chk("fin_done_held", int'(done), 1);
    chk("fin_rd_idle", int'(res_rd), 0);
    do_start(0);
    chk("restart_done_clr", int'(done), 0);
    chk("restart_max_clr", int'(max_dist), 0);
    chk("restart_cnt_clr", int'(obj_cnt), 0);
    chk("restart_rd", int'(res_rd), 1);
    wait_done();
    chk("zero_max", int'(max_dist), 0);
    chk("zero_cnt", int'(obj_cnt), 0);
    chk("zero_word1023", int'(got[1023]), 0);

    // Frame C: single object pixel, aborted by reset at cycle 9000.
    mem[16383] = 8'd1;
    do_start(0);
    while (cyc < t_start + 9000) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_rd", int'(res_rd), 0);
      chk("post_reset_wr", int'(out_wr), 0);
    end

    // Frame C again with start held high: back-to-back frames, one done cycle.
    do_start(1);
    wait_done();
    chk("pix_max", int'(max_dist), 1);
    chk("pix_cnt", int'(obj_cnt), 1);
    chk("pix_word1023", int'(got[1023]), 16'h0001);
    chk("pix_word1022", int'(got[1022]), 16'h0000);
    @(negedge clk);
    chk("b2b_done_one_cycle", int'(done), 0);
    chk("b2b_restart_rd", int'(res_rd), 1);
    chk("b2b_restart_addr", int'(res_addr), 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
